// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the binary32 multiply/add unit: field widths,
// exponent bias, canonical special encodings, the field-unpack struct, the
// operation select encoding and a leading-zero counter used by the add
// path's normalizer.
// ---------------------------------------------------------------------------
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int FP_BIAS = 127;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_PINF = 32'h7F800000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_fields_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_ADD = 1'b1
  } fp_op_e;

  // Signed infinity built from the positive encoding.
  function automatic logic [31:0] fp_inf(input logic sign);
    return FP_PINF | {sign, 31'd0};
  endfunction

  // Number of zeros above the most significant set bit of a 27-bit value.
  // An all-zero input returns 0; callers detect that case separately.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) cnt = 5'(26 - i);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fp_mul_add_if.sv
// ---------------------------------------------------------------------------
// fp_mul_add_if
// Operand/result bundle of the FP multiply/add unit. There is no handshake:
// the unit samples op/rs1/rs2 on every rising edge.
//   op   : 0 = multiply, 1 = add          (master -> slave)
//   rs1  : binary32 operand A             (master -> slave)
//   rs2  : binary32 operand B             (master -> slave)
//   out  : registered binary32 result     (slave -> master)
// ---------------------------------------------------------------------------
interface fp_mul_add_if;

  logic        op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] out;

  modport master (output op, rs1, rs2, input out);
  modport slave  (input op, rs1, rs2, output out);

endinterface

// File: rtl/fp_round_pack.sv
// ---------------------------------------------------------------------------
// fp_round_pack
// Round-to-nearest-even and packing stage shared by the multiply and add
// paths.
//   sign    : result sign
//   exp_in  : signed biased exponent belonging to sig[26]
//   sig     : {1.fraction (24 bits), guard, round, sticky}, normalized
//   is_zero : exact zero result, packed as a signed zero
//   result  : packed binary32 (overflow -> +/-Inf, underflow -> +/-0)
// ---------------------------------------------------------------------------
module fp_round_pack
  import fp_pkg::*;
(
  input  logic               sign,
  input  logic signed [9:0]  exp_in,
  input  logic [26:0]        sig,
  input  logic               is_zero,
  output logic [31:0]        result
);

  logic               round_up;
  logic [24:0]        rounded;
  logic [23:0]        mant;
  logic signed [9:0]  exp_r;

  // Ties go to the even mantissa: round up when above half, or exactly half
  // with an odd LSB. A carry out of the mantissa bumps the exponent and
  // leaves a 1.000... significand, so the shifted value is still correct.
  always_comb begin
    round_up = sig[2] & (sig[1] | sig[0] | sig[3]);
    rounded  = {1'b0, sig[26:3]} + {24'd0, round_up};
    if (rounded[24]) begin
      mant  = rounded[24:1];
      exp_r = exp_in + 10'sd1;
    end else begin
      mant  = rounded[23:0];
      exp_r = exp_in;
    end

    if (is_zero) begin
      result = {sign, 31'd0};
    end else if (exp_r >= 10'sd255) begin
      result = fp_inf(sign);
    end else if (exp_r <= 10'sd0) begin
      result = {sign, 31'd0};
    end else begin
      result = {sign, exp_r[7:0], mant[22:0]};
    end
  end

endmodule

// File: rtl/fp_mul_add.sv
// ---------------------------------------------------------------------------
// fp_mul_add
// Single-precision multiply or add with a fixed one-cycle latency and one
// result per cycle. Subnormal inputs and results are flushed to zero,
// rounding is round-to-nearest-even, NaNs come out as the canonical qNaN.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears the result register
//   bus   : op/rs1/rs2 in, registered out (fp_mul_add_if.slave)
// ---------------------------------------------------------------------------
module fp_mul_add
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  fp_mul_add_if.slave bus
);

  fp_fields_t a, b;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  // Operand classification; exponent 0 means zero because subnormals are
  // flushed.
  always_comb begin
    a      = bus.rs1;
    b      = bus.rs2;
    a_zero = (a.exp == 8'd0);
    b_zero = (b.exp == 8'd0);
    a_inf  = (a.exp == 8'hFF) && (a.frac == 23'd0);
    b_inf  = (b.exp == 8'hFF) && (b.frac == 23'd0);
    a_nan  = (a.exp == 8'hFF) && (a.frac != 23'd0);
    b_nan  = (b.exp == 8'hFF) && (b.frac != 23'd0);
  end

  logic [47:0]       prod;
  logic              mul_sign, mul_zero;
  logic signed [9:0] mul_exp;
  logic [26:0]       mul_sig;

  // Multiply: the 48-bit product of two 1.x significands lies in [1,4), so
  // at most one right shift normalizes it. Everything below the round bit
  // folds into sticky.
  always_comb begin
    prod     = {24'd0, 1'b1, a.frac} * {24'd0, 1'b1, b.frac};
    mul_sign = a.sign ^ b.sign;
    mul_zero = a_zero | b_zero;
    mul_exp  = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp})
             - $signed(10'(FP_BIAS)) + (prod[47] ? 10'sd1 : 10'sd0);
    if (prod[47]) begin
      mul_sig = {prod[47:24], prod[23], prod[22], |prod[21:0]};
    end else begin
      mul_sig = {prod[46:23], prod[22], prod[21], |prod[20:0]};
    end
  end

  logic [30:0]       a_mag, b_mag, big_mag, small_mag;
  logic              big_sign, eff_sub;
  logic [23:0]       big_sig, small_sig;
  logic [7:0]        exp_diff;
  logic [4:0]        shift_amt, lz;
  logic [26:0]       big_ext, small_ext, shifted, lost_mask, aligned;
  logic [27:0]       sum;
  logic              add_sign, add_zero;
  logic signed [9:0] add_exp;
  logic [26:0]       add_sig;

  // Add: order by magnitude so the difference is never negative, align the
  // smaller operand with a capped shift (bits pushed out jam into bit 0),
  // then normalize by one right shift on carry or a leading-zero left shift.
  // The capped shift still lands the hidden bit in the sticky position, so
  // far-apart operands round correctly.
  always_comb begin
    a_mag     = a_zero ? 31'd0 : bus.rs1[30:0];
    b_mag     = b_zero ? 31'd0 : bus.rs2[30:0];
    if (a_mag >= b_mag) begin
      big_mag   = a_mag;
      small_mag = b_mag;
      big_sign  = a.sign;
    end else begin
      big_mag   = b_mag;
      small_mag = a_mag;
      big_sign  = b.sign;
    end
    big_sig   = (big_mag == 31'd0)   ? 24'd0 : {1'b1, big_mag[22:0]};
    small_sig = (small_mag == 31'd0) ? 24'd0 : {1'b1, small_mag[22:0]};
    exp_diff  = big_mag[30:23] - small_mag[30:23];
    shift_amt = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
    big_ext   = {big_sig, 3'b000};
    small_ext = {small_sig, 3'b000};
    shifted   = small_ext >> shift_amt;
    lost_mask = ~(27'h7FFFFFF << shift_amt);
    aligned   = {shifted[26:1], shifted[0] | (|(small_ext & lost_mask))};
    eff_sub   = a.sign ^ b.sign;
    sum       = eff_sub ? ({1'b0, big_ext} - {1'b0, aligned})
                        : ({1'b0, big_ext} + {1'b0, aligned});
    lz        = lzc27(sum[26:0]);
    add_zero  = (sum == 28'd0);
    // Exact zero is +0 unless both inputs were -0.
    add_sign  = add_zero ? (a.sign & b.sign) : big_sign;
    if (sum[27]) begin
      add_sig = {sum[27:2], sum[1] | sum[0]};
      add_exp = $signed({2'b00, big_mag[30:23]}) + 10'sd1;
    end else begin
      add_sig = sum[26:0] << lz;
      add_exp = $signed({2'b00, big_mag[30:23]}) - $signed({5'd0, lz});
    end
  end

  logic              rp_sign, rp_zero;
  logic signed [9:0] rp_exp;
  logic [26:0]       rp_sig;
  logic [31:0]       rp_result;

  // One rounder serves both paths; op picks which one feeds it.
  always_comb begin
    if (fp_op_e'(bus.op) == OP_ADD) begin
      rp_sign = add_sign;
      rp_exp  = add_exp;
      rp_sig  = add_sig;
      rp_zero = add_zero;
    end else begin
      rp_sign = mul_sign;
      rp_exp  = mul_exp;
      rp_sig  = mul_sig;
      rp_zero = mul_zero;
    end
  end

  fp_round_pack u_round_pack (
    .sign    (rp_sign),
    .exp_in  (rp_exp),
    .sig     (rp_sig),
    .is_zero (rp_zero),
    .result  (rp_result)
  );

  logic        special;
  logic [31:0] special_val;
  logic [31:0] next_out;

  // NaN and infinity inputs bypass the arithmetic; invalid combinations
  // (Inf*0, Inf-Inf) produce the canonical qNaN.
  always_comb begin
    special     = 1'b0;
    special_val = FP_QNAN;
    if (a_nan | b_nan) begin
      special = 1'b1;
    end else if (fp_op_e'(bus.op) == OP_MUL) begin
      if ((a_inf & b_zero) | (b_inf & a_zero)) begin
        special = 1'b1;
      end else if (a_inf | b_inf) begin
        special     = 1'b1;
        special_val = fp_inf(a.sign ^ b.sign);
      end
    end else begin
      if (a_inf & b_inf & (a.sign != b.sign)) begin
        special = 1'b1;
      end else if (a_inf) begin
        special     = 1'b1;
        special_val = fp_inf(a.sign);
      end else if (b_inf) begin
        special     = 1'b1;
        special_val = fp_inf(b.sign);
      end
    end
    next_out = special ? special_val : rp_result;
  end

  // Single output register; reset drops any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out <= 32'd0;
    end else begin
      bus.out <= next_out;
    end
  end

endmodule

// File: tb/tb_fp_mul_add.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_add
// Self-checking bench for fp_mul_add. A behavioural reference computes each
// result from exact wide-integer arithmetic with unbounded-exponent
// round-to-nearest-even, then applies overflow/flush rules. A compare
// process checks the registered output against that reference every cycle;
// directed vectors pin both the DUT and the reference to literal values.
// ---------------------------------------------------------------------------
module tb_fp_mul_add;

  logic clk;
  logic reset;
  fp_mul_add_if bus();

  fp_mul_add dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic        run_compare = 1'b0;
  logic [31:0] model_out   = 32'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Exact RNE rounding of mag; the biased exponent of the result, before
  // rounding, is (index of mag's top set bit) + base.
  function automatic logic [31:0] model_pack(input logic sign,
                                             input logic [287:0] mag,
                                             input int base);
    int p, sh, bexp;
    logic [287:0] kept, rem, half;
    p = -1;
    for (int i = 0; i < 288; i++) if (mag[i]) p = i;
    if (p < 0) return {sign, 31'd0};
    bexp = p + base;
    if (p > 23) begin
      sh   = p - 23;
      kept = mag >> sh;
      rem  = mag - (kept << sh);
      half = 288'd1 << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 288'd1;
      if (kept[24]) begin
        kept = kept >> 1;
        bexp = bexp + 1;
      end
    end else begin
      kept = mag << (23 - p);
    end
    if (bexp >= 255) return {sign, 8'hFF, 23'd0};
    if (bexp <= 0) return {sign, 31'd0};
    return {sign, bexp[7:0], kept[22:0]};
  endfunction

  function automatic logic [31:0] ref_model(input logic op,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    int ex, ey, lo;
    logic xz, yz, xi, yi, xn, yn, s;
    logic [287:0] ax, ay, mag;
    logic [47:0] prod;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 23'd0);
    yi = (ey == 255) && (y[22:0] == 23'd0);
    xn = (ex == 255) && (x[22:0] != 23'd0);
    yn = (ey == 255) && (y[22:0] != 23'd0);
    if (xn || yn) return 32'h7FC00000;
    if (!op) begin
      if ((xi && yz) || (yi && xz)) return 32'h7FC00000;
      if (xi || yi) return {x[31] ^ y[31], 8'hFF, 23'd0};
      if (xz || yz) return {x[31] ^ y[31], 31'd0};
      prod = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
      mag = '0;
      mag[47:0] = prod;
      return model_pack(x[31] ^ y[31], mag, ex + ey - 173);
    end
    if (xi && yi && (x[31] != y[31])) return 32'h7FC00000;
    if (xi) return x;
    if (yi) return y;
    if (xz && yz) return {x[31] & y[31], 31'd0};
    if (xz) return y;
    if (yz) return x;
    lo = (ex < ey) ? ex : ey;
    ax = '0;
    ay = '0;
    ax[23:0] = {1'b1, x[22:0]};
    ay[23:0] = {1'b1, y[22:0]};
    ax = ax << (ex - lo);
    ay = ay << (ey - lo);
    if (x[31] == y[31]) begin
      mag = ax + ay;
      s   = x[31];
    end else if (ax >= ay) begin
      mag = ax - ay;
      s   = x[31];
    end else begin
      mag = ay - ax;
      s   = y[31];
    end
    if (mag == '0) return 32'h00000000;
    return model_pack(s, mag, lo - 23);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
    end
  endtask

  // Reference register: the result of the inputs seen at each rising edge,
  // cleared by reset.
  always @(posedge clk or posedge reset) begin
    if (reset) model_out = 32'd0;
    else model_out = ref_model(bus.op, bus.rs1, bus.rs2);
  end

  always @(negedge clk) begin
    if (run_compare) checkOutput("cycle", bus.out, model_out);
  end

  // Drive at a falling edge, then check the literal one cycle later. The
  // literal is also checked against the reference model.
  task automatic applyStimulus(input string name, input logic op,
                               input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] expected);
    bus.op  = op;
    bus.rs1 = x;
    bus.rs2 = y;
    checkOutput({"model_", name}, ref_model(op, x, y), expected);
    @(negedge clk);
    checkOutput(name, bus.out, expected);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [8];
    logic [31:0] v;
    int kind;
    specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00001, 32'h00000001, 32'h7F7FFFFF, 32'h00800000};
    kind = $urandom_range(0, 9);
    case (kind)
      0: v = $urandom();
      1: v = specials[$urandom_range(0, 7)];
      2: v = {1'($urandom()), 8'($urandom_range(1, 3)), 23'($urandom())};
      3: v = {1'($urandom()), 8'($urandom_range(252, 254)), 23'($urandom())};
      default: v = {1'($urandom()), 8'($urandom_range(100, 154)), 23'($urandom())};
    endcase
    return v;
  endfunction

  initial begin
    reset   = 1'b1;
    bus.op  = 1'b0;
    bus.rs1 = 32'd0;
    bus.rs2 = 32'd0;
    @(negedge clk);
    run_compare = 1'b1;
    @(negedge clk);
    checkOutput("reset_state", bus.out, 32'h00000000);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors, back-to-back with op alternating.
    applyStimulus("mul_1p5x1p5",  1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    applyStimulus("add_1p1",      1'b1, 32'h3F800000, 32'h3F800000, 32'h40000000);
    applyStimulus("mul_0p5x4",    1'b0, 32'h3F000000, 32'h40800000, 32'h40000000);
    applyStimulus("add_cancel",   1'b1, 32'h3FC00000, 32'hBFC00000, 32'h00000000);
    applyStimulus("mul_inf_zero", 1'b0, 32'h7F800000, 32'h00000000, 32'h7FC00000);
    applyStimulus("add_negzeros", 1'b1, 32'h80000000, 32'h80000000, 32'h80000000);
    applyStimulus("mul_overflow", 1'b0, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000);
    applyStimulus("add_tie_even", 1'b1, 32'h3F800000, 32'h33800000, 32'h3F800000);
    applyStimulus("mul_ftz",      1'b0, 32'h00800000, 32'h3F000000, 32'h00000000);
    applyStimulus("add_tie_up",   1'b1, 32'h3F800001, 32'h33800000, 32'h3F800002);
    applyStimulus("mul_nan",      1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    applyStimulus("add_inf_ninf", 1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
    applyStimulus("add_inf_fin",  1'b1, 32'hFF800000, 32'h3F800000, 32'hFF800000);
    applyStimulus("mul_inf_fin",  1'b0, 32'h7F800000, 32'hC0000000, 32'hFF800000);

    // Randomized stream; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      bus.op  = (i < 8) ? 1'(i) : 1'($urandom());
      bus.rs1 = rand_operand();
      if ($urandom_range(0, 7) == 0) begin
        bus.rs2 = {~bus.rs1[31], bus.rs1[30:4], 4'($urandom())};
      end else begin
        bus.rs2 = rand_operand();
      end
      @(negedge clk);
    end

    // Asynchronous reset between edges while the output is non-zero.
    applyStimulus("pre_reset", 1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    bus.op  = 1'b1;
    bus.rs1 = 32'h40400000;
    bus.rs2 = 32'h40400000;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_async", bus.out, 32'h00000000);
    for (int i = 0; i < 3; i++) begin
      bus.rs1 = rand_operand();
      bus.rs2 = rand_operand();
      @(negedge clk);
      checkOutput("reset_held", bus.out, 32'h00000000);
    end
    reset = 1'b0;
    applyStimulus("post_reset", 1'b1, 32'h3F800000, 32'h3F800000, 32'h40000000);
    applyStimulus("post_reset2", 1'b0, 32'h3F000000, 32'h40800000, 32'h40000000);

    run_compare = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
